// File: rtl/riscv_mem_pkg.sv
// Shared data-memory encodings: func3 access codes, responder FSM states
// and the access legality rule used by both the core and the responder.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        INIT,
        READY
    } mem_state_t;

    // True when func3 is a known size, the offset is naturally aligned for
    // that size, and unsigned codes are not used with a store.
    function automatic logic access_ok(input logic [2:0] f3,
                                       input logic [1:0] offset,
                                       input logic       is_store);
        case (f3)
            F3_B:    access_ok = 1'b1;
            F3_BU:   access_ok = !is_store;
            F3_H:    access_ok = !offset[0];
            F3_HU:   access_ok = !is_store && !offset[0];
            F3_W:    access_ok = (offset == 2'b00);
            default: access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory: store byte-enables and replicated
// store data, plus load extraction with sign/zero extension.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Decode lanes for stores and extract/extend the addressed lanes for loads.
    always_comb begin
        byte_en    = '0;
        store_word = '0;
        load_data  = '0;
        shifted    = load_word >> {offset, 3'b000};
        case (func3)
            F3_B: begin
                byte_en    = 4'b0001 << offset;
                store_word = {4{store_data[7:0]}};
                load_data  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                load_data  = {24'h000000, shifted[7:0]};
            end
            F3_H: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                load_data  = {16'h0000, shifted[15:0]};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                store_word = store_data;
                load_data  = load_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: clears storage after reset, then serves byte/half/
// word loads and stores with one cycle of load latency.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [AddrWidth-1:0] mem_address,
    input  logic                 mem_read_en,
    input  logic                 mem_write_en,
    input  logic [DataWidth-1:0] mem_dataIn,
    input  logic [2:0]           func3,
    output logic [DataWidth-1:0] mem_dataOut,
    output logic                 busy,
    output logic                 misalign_err
);

    localparam int WordAw = AddrWidth - 2;
    localparam int Depth  = 1 << WordAw;
    localparam logic [WordAw-1:0] LastIdx = '1;

    mem_state_t          state, state_next;
    logic [WordAw-1:0]   clr_cnt;
    logic [DataWidth-1:0] storage [Depth];

    logic [WordAw-1:0]   word_idx;
    logic [1:0]          offset;
    logic                req;
    logic                ok;
    logic                do_store;
    logic [3:0]          byte_en;
    logic [DataWidth-1:0] store_word;
    logic [DataWidth-1:0] load_data;

    assign word_idx = mem_address[AddrWidth-1:2];
    assign offset   = mem_address[1:0];
    assign req      = mem_read_en || mem_write_en;
    assign ok       = access_ok(func3, offset, mem_write_en);
    assign do_store = (state == READY) && mem_write_en && ok;

    mem_lane_align u_align (
        .func3      (func3),
        .offset     (offset),
        .store_data (mem_dataIn),
        .load_word  (storage[word_idx]),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data)
    );

    // State register and init clear counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Next state: leave INIT once the last word has been cleared.
    always_comb begin
        state_next = state;
        busy       = (state == INIT);
        if (state == INIT && clr_cnt == LastIdx) begin
            state_next = READY;
        end
    end

    // Storage writes: init clear, or lane-masked store; contents have no reset.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            storage[clr_cnt] <= '0;
        end else if (do_store) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    storage[word_idx][i*8 +: 8] <= store_word[i*8 +: 8];
                end
            end
        end
    end

    // Load result register and one-cycle error pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_dataOut  <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (state == READY && req) begin
                if (!ok) begin
                    mem_dataOut  <= '0;
                    misalign_err <= 1'b1;
                end else if (mem_write_en) begin
                    mem_dataOut <= '0;
                end else begin
                    mem_dataOut <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized traffic against a byte-array reference model.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  mem_address = '0;
    logic        mem_read_en = 1'b0;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_dataIn = '0;
    logic [2:0]  func3 = '0;
    logic [31:0] mem_dataOut;
    logic        busy;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_model [1024];
    logic        model_ready = 1'b0;
    logic [31:0] last_out = '0;
    logic [31:0] exp_out;
    logic        exp_err;

    data_mem_responder #(.DataWidth(32), .AddrWidth(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_address  (mem_address),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_dataIn   (mem_dataIn),
        .func3        (func3),
        .mem_dataOut  (mem_dataOut),
        .busy         (busy),
        .misalign_err (misalign_err)
    );

    always #5 clock = ~clock;

    function automatic int unsigned access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: access_size = 1;
            3'b001, 3'b101: access_size = 2;
            3'b010:         access_size = 4;
            default:        access_size = 0;
        endcase
    endfunction

    function automatic logic model_legal(input logic wr, input logic [9:0] addr,
                                         input logic [2:0] f3);
        int unsigned sz;
        sz = access_size(f3);
        if (sz == 0) return 1'b0;
        if (wr && f3[2]) return 1'b0;
        return (int'(addr) % sz) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [9:0] addr, input logic [2:0] f3);
        int unsigned a;
        logic [7:0]  b;
        logic [15:0] h;
        a = addr;
        case (f3)
            3'b000: begin b = mem_model[a]; return {{24{b[7]}}, b}; end
            3'b100: begin b = mem_model[a]; return {24'h0, b}; end
            3'b001: begin h = {mem_model[a+1], mem_model[a]}; return {{16{h[15]}}, h}; end
            3'b101: begin h = {mem_model[a+1], mem_model[a]}; return {16'h0, h}; end
            default: return {mem_model[a+3], mem_model[a+2], mem_model[a+1], mem_model[a]};
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
        last_out = '0;
    endtask

    // Reference behaviour of one request cycle; sets exp_out / exp_err.
    task automatic model_step(input logic rd, input logic wr, input logic [9:0] addr,
                              input logic [2:0] f3, input logic [31:0] d);
        exp_err = 1'b0;
        exp_out = last_out;
        if (model_ready && (rd || wr)) begin
            if (!model_legal(wr, addr, f3)) begin
                exp_out = '0;
                exp_err = 1'b1;
            end else if (wr) begin
                for (int k = 0; k < int'(access_size(f3)); k++)
                    mem_model[int'(addr) + k] = d[8*k +: 8];
                exp_out = '0;
            end else begin
                exp_out = model_load(addr, f3);
            end
        end
        last_out = exp_out;
    endtask

    // Drive one request for one clock edge, sample 1 time unit after it.
    task automatic do_req(input logic rd, input logic wr, input logic [9:0] addr,
                          input logic [2:0] f3, input logic [31:0] d);
        mem_read_en  = rd;
        mem_write_en = wr;
        mem_address  = addr;
        func3        = f3;
        mem_dataIn   = d;
        @(posedge clock);
        #1;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        model_step(rd, wr, addr, f3, d);
    endtask

    // Count cycles until busy falls, bounded.
    task automatic wait_init(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
        end
        model_ready = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        model_ready = 1'b0;
        reset = 1'b0;
        #12;
        if (mem_dataOut !== 32'h0 || misalign_err !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL reset_state: out=%h err=%b busy=%b, need out=0 err=0 busy=1",
                     mem_dataOut, misalign_err, busy);
            errors++;
        end
        checks++;
        @(posedge clock);
        #3;
        reset = 1'b1;
        model_clear();
        wait_init(n);
        if (n != 256) begin
            $display("FAIL init_length: busy cycles=%0d, need 256", n);
            errors++;
        end
        checks++;
        @(posedge clock);
        #1;
        do_req(1'b1, 1'b0, 10'h3FC, 3'b010, 32'h0);
        if (mem_dataOut !== 32'h0) begin
            $display("FAIL lw_top_after_init: got %h, need 00000000", mem_dataOut);
            errors++;
        end
        checks++;
    endtask

    task automatic test_word();
        logic [31:0] want [3];
        logic [2:0]  f3s  [3];
        logic [9:0]  adrs [3];
        want = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE};
        f3s  = '{3'b010, 3'b000, 3'b100};
        adrs = '{10'h010, 10'h013, 10'h013};
        do_req(1'b0, 1'b1, 10'h010, 3'b010, 32'hDEADBEEF);
        if (mem_dataOut !== 32'h0 || misalign_err !== 1'b0) begin
            $display("FAIL sw_response: out=%h err=%b, need 0/0", mem_dataOut, misalign_err);
            errors++;
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 1'b0, adrs[i], f3s[i], 32'h0);
            if (mem_dataOut !== want[i]) begin
                $display("FAIL word_load[%0d]: got %h, need %h", i, mem_dataOut, want[i]);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_half();
        logic [31:0] want [3];
        logic [2:0]  f3s  [3];
        logic [9:0]  adrs [3];
        want = '{32'h80013344, 32'hFFFF8001, 32'h00008001};
        f3s  = '{3'b010, 3'b001, 3'b101};
        adrs = '{10'h020, 10'h022, 10'h022};
        do_req(1'b0, 1'b1, 10'h020, 3'b010, 32'h11223344);
        do_req(1'b0, 1'b1, 10'h022, 3'b001, 32'h00008001);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 1'b0, adrs[i], f3s[i], 32'h0);
            if (mem_dataOut !== want[i]) begin
                $display("FAIL half_load[%0d]: got %h, need %h", i, mem_dataOut, want[i]);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_byte();
        do_req(1'b0, 1'b1, 10'h031, 3'b000, 32'h123456AB);
        do_req(1'b1, 1'b0, 10'h030, 3'b010, 32'h0);
        if (mem_dataOut !== 32'h0000AB00) begin
            $display("FAIL sb_lane1: got %h, need 0000ab00", mem_dataOut);
            errors++;
        end
        checks++;
    endtask

    task automatic test_misalign();
        logic [31:0] hold;
        do_req(1'b0, 1'b1, 10'h004, 3'b010, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 10'h004, 3'b010, 32'h0);
        do_req(1'b1, 1'b0, 10'h005, 3'b010, 32'h0);
        if (mem_dataOut !== 32'h0 || misalign_err !== 1'b1) begin
            $display("FAIL lw_misaligned: out=%h err=%b, need 0/1", mem_dataOut, misalign_err);
            errors++;
        end
        checks++;
        do_req(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
        if (misalign_err !== 1'b0) begin
            $display("FAIL err_pulse_width: err=%b, need 0", misalign_err);
            errors++;
        end
        checks++;
        do_req(1'b0, 1'b1, 10'h003, 3'b001, 32'h0000FFFF);
        if (mem_dataOut !== 32'h0 || misalign_err !== 1'b1) begin
            $display("FAIL sh_misaligned: out=%h err=%b, need 0/1", mem_dataOut, misalign_err);
            errors++;
        end
        checks++;
        do_req(1'b0, 1'b1, 10'h004, 3'b100, 32'h000000FF);
        if (misalign_err !== 1'b1) begin
            $display("FAIL store_unsigned_code: err=%b, need 1", misalign_err);
            errors++;
        end
        checks++;
        do_req(1'b1, 1'b0, 10'h004, 3'b011, 32'h0);
        if (misalign_err !== 1'b1) begin
            $display("FAIL illegal_func3: err=%b, need 1", misalign_err);
            errors++;
        end
        checks++;
        do_req(1'b1, 1'b0, 10'h004, 3'b010, 32'h0);
        hold = mem_dataOut;
        if (hold !== 32'hCAFEF00D) begin
            $display("FAIL word4_unchanged: got %h, need cafef00d", hold);
            errors++;
        end
        checks++;
        do_req(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
        if (mem_dataOut !== 32'hCAFEF00D) begin
            $display("FAIL idle_hold: got %h, need cafef00d", mem_dataOut);
            errors++;
        end
        checks++;
    endtask

    task automatic test_read_write_both();
        do_req(1'b1, 1'b1, 10'h050, 3'b010, 32'hA5A55A5A);
        if (mem_dataOut !== 32'h0 || misalign_err !== 1'b0) begin
            $display("FAIL rw_both_resp: out=%h err=%b, need 0/0", mem_dataOut, misalign_err);
            errors++;
        end
        checks++;
        do_req(1'b1, 1'b0, 10'h052, 3'b101, 32'h0);
        if (mem_dataOut !== 32'h0000A5A5) begin
            $display("FAIL rw_both_store: got %h, need 0000a5a5", mem_dataOut);
            errors++;
        end
        checks++;
    endtask

    task automatic test_random();
        logic        rd, wr;
        logic [9:0]  addr;
        logic [2:0]  f3;
        logic [31:0] d;
        int unsigned kind;
        logic [2:0]  f3_pool [10];
        f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                    3'b010, 3'b000, 3'b001, 3'b011, 3'b111};
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 9);
            rd = (kind < 5) || (kind == 9);
            wr = (kind >= 5) && (kind < 9) || (kind == 9 && $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) begin
                rd = 1'b0;
                wr = 1'b0;
            end
            if ($urandom_range(0, 4) == 0)
                addr = 10'(960 + $urandom_range(0, 63));
            else
                addr = 10'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0)
                addr = addr & 10'h3FC;
            f3 = f3_pool[$urandom_range(0, 9)];
            d  = $urandom;
            do_req(rd, wr, addr, f3, d);
            if (mem_dataOut !== exp_out) begin
                $display("FAIL rand_out[%0d] rd=%b wr=%b a=%h f3=%b: got %h, need %h",
                         i, rd, wr, addr, f3, mem_dataOut, exp_out);
                errors++;
            end
            checks++;
            if (misalign_err !== exp_err) begin
                $display("FAIL rand_err[%0d] rd=%b wr=%b a=%h f3=%b: got %b, need %b",
                         i, rd, wr, addr, f3, misalign_err, exp_err);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            logic [9:0]  a;
            d = $urandom;
            a = 10'(($urandom_range(0, 255)) * 4);
            do_req(1'b0, 1'b1, a, 3'b010, d);
            do_req(1'b1, 1'b0, a, 3'b010, 32'h0);
            if (mem_dataOut !== d) begin
                $display("FAIL back_to_back[%0d] a=%h: got %h, need %h", i, a, mem_dataOut, d);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        do_req(1'b1, 1'b0, 10'h004, 3'b010, 32'h0);
        #2;
        reset = 1'b0;
        model_ready = 1'b0;
        #1;
        if (mem_dataOut !== 32'h0 || busy !== 1'b1) begin
            $display("FAIL reset_mid_access: out=%h busy=%b, need 0/1", mem_dataOut, busy);
            errors++;
        end
        checks++;
        @(posedge clock);
        #3;
        reset = 1'b1;
        model_clear();
        repeat (100) begin
            @(posedge clock);
            #1;
        end
        do_req(1'b0, 1'b1, 10'h040, 3'b010, 32'h12345678);
        if (busy !== 1'b1 || mem_dataOut !== 32'h0 || misalign_err !== 1'b0) begin
            $display("FAIL store_while_busy: busy=%b out=%h err=%b, need 1/0/0",
                     busy, mem_dataOut, misalign_err);
            errors++;
        end
        checks++;
        #2;
        reset = 1'b0;
        #5;
        reset = 1'b1;
        wait_init(n);
        if (n != 256) begin
            $display("FAIL init_restart_length: busy cycles=%0d, need 256", n);
            errors++;
        end
        checks++;
        do_req(1'b1, 1'b0, 10'h040, 3'b010, 32'h0);
        if (mem_dataOut !== 32'h0) begin
            $display("FAIL busy_store_ignored: got %h, need 00000000", mem_dataOut);
            errors++;
        end
        checks++;
        do_req(1'b1, 1'b0, 10'h010, 3'b010, 32'h0);
        if (mem_dataOut !== 32'h0) begin
            $display("FAIL cleared_after_reinit: got %h, need 00000000", mem_dataOut);
            errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_half();
        test_byte();
        test_misalign();
        test_read_write_both();
        test_back_to_back();
        test_random();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
